// File: rtl/uart_prog_loader.sv
// UART 8N1 receiver feeding little-endian 32-bit words into instruction memory.
// Ends the load after a line-idle timeout, flushing any partial word zero-padded.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 87,
  parameter int ADDR_W       = 12,
  parameter int IDLE_TIMEOUT = 20 * 87
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic              load_done_o,
  output logic              frame_err_o,
  output logic              overrun_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO  = TW'(IDLE_TIMEOUT);
  localparam logic [ADDR_W:0] CMAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t            state, state_n;
  logic              rx_m, rx_s;
  logic [CW-1:0]     cnt, cnt_n;
  logic [2:0]        idx, idx_n;
  logic [7:0]        shreg, shreg_n;
  logic              byte_v, ferr;

  logic [1:0]        bsel;
  logic [23:0]       wbuf;
  logic              seen;
  logic [TW-1:0]     timer;
  logic [ADDR_W-1:0] addr;
  logic              byte_ok, accept, busy, timeout, flush, word_rdy;
  logic [31:0]       word;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_m  <= 1'b1;
      rx_s  <= 1'b1;
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      rx_m  <= rx_i;
      rx_s  <= rx_m;
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shreg_n = shreg;
    byte_v  = 1'b0;
    ferr    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: if (cnt == HALF) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_n   = '0;
        shreg_n = {rx_s, shreg[7:1]};
        idx_n   = idx + 3'd1;
        if (idx == 3'd7) state_n = STOP;
      end
      STOP: if (cnt == LAST) begin
        cnt_n = '0;
        if (rx_s) begin
          byte_v  = 1'b1;
          state_n = IDLE;
        end else begin
          ferr    = 1'b1;
          state_n = BRK;
        end
      end
      BRK: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // A write retiring this cycle frees the slot for a word completing now.
  assign byte_ok  = byte_v && !load_done_o;
  assign accept   = mem_valid_o && mem_ready_i;
  assign busy     = mem_valid_o && !mem_ready_i;
  assign timeout  = (timer == TMO);
  assign flush    = timeout && (bsel != 2'd0);
  assign word_rdy = (byte_ok && bsel == 2'd3) || flush;
  assign word     = byte_ok ? {shreg, wbuf} : {8'h00, wbuf};
  assign mem_addr_o = addr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_valid_o  <= 1'b0;
      mem_wdata_o  <= '0;
      word_count_o <= '0;
      load_done_o  <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
      addr         <= '0;
      bsel         <= '0;
      wbuf         <= '0;
      seen         <= 1'b0;
      timer        <= '0;
    end else begin
      frame_err_o <= ferr && !load_done_o;
      if (accept) begin
        mem_valid_o <= 1'b0;
        addr        <= addr + 1'b1;
        if (word_count_o != CMAX) word_count_o <= word_count_o + 1'b1;
      end
      if (byte_ok) begin
        seen  <= 1'b1;
        timer <= '0;
        unique case (bsel)
          2'd0:    wbuf[7:0]   <= shreg;
          2'd1:    wbuf[15:8]  <= shreg;
          2'd2:    wbuf[23:16] <= shreg;
          default: ;
        endcase
        if (bsel != 2'd3) bsel <= bsel + 2'd1;
      end else if (seen && state == IDLE && !timeout && !load_done_o) begin
        timer <= timer + 1'b1;
      end
      if (word_rdy) begin
        bsel <= '0;
        wbuf <= '0;
        if (busy) begin
          overrun_o <= 1'b1;
        end else begin
          mem_valid_o <= 1'b1;
          mem_wdata_o <= word;
        end
      end
      if (timeout && bsel == 2'd0 && !mem_valid_o) load_done_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: table of byte streams plus
// hand-written sequences for framing errors, overrun, glitches and reset.
module tb_uart_prog_loader;
  localparam int CPB = 87;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        ready;
  logic        mem_valid;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [12:0] word_count;
  logic        load_done;
  logic        frame_err;
  logic        overrun;

  uart_prog_loader dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx),
    .mem_valid_o(mem_valid), .mem_ready_i(ready),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .word_count_o(word_count), .load_done_o(load_done),
    .frame_err_o(frame_err), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ferr_cnt = 0;
  logic [11:0] wa[$];
  logic [31:0] wd[$];

  always @(negedge clk) begin
    if (mem_valid && ready) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (frame_err) ferr_cnt++;
  end

  typedef struct {
    logic [63:0] bytes;
    int          n;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t tv[4];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stopb = 1'b1);
    rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(CPB);
    end
    rx = stopb;
    cyc(CPB);
    rx = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    cyc(3);
    rst = 1'b0;
    wa.delete();
    wd.delete();
    ferr_cnt = 0;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!load_done && k < 4000) begin
      cyc(1);
      k++;
    end
    chk({nm, "_done"}, load_done, 1);
  endtask

  function automatic logic [63:0] outs();
    return {mem_valid, mem_addr, mem_wdata, word_count,
            load_done, frame_err, overrun};
  endfunction

  initial begin
    tv[0] = '{64'h00000000_00200113, 4, 1, 32'h00200113, 32'h0};
    tv[1] = '{64'h00000093_00200113, 8, 2, 32'h00200113, 32'h00000093};
    tv[2] = '{64'h0000_0000_0000_BBAA, 2, 1, 32'h0000BBAA, 32'h0};
    tv[3] = '{64'h00000055_44332211, 5, 2, 32'h44332211, 32'h00000055};

    rst = 1'b1;
    rx = 1'b1;
    ready = 1'b1;
    cyc(4);
    chk("reset_outs", outs(), 64'h0);

    for (int i = 0; i < 4; i++) begin
      do_reset();
      ready = 1'b1;
      for (int j = 0; j < tv[i].n; j++) send(tv[i].bytes[8*j +: 8]);
      cyc(1000);
      chk($sformatf("v%0d_early_done", i), load_done, 0);
      wait_done($sformatf("v%0d", i));
      chk($sformatf("v%0d_nwrites", i), wa.size(), tv[i].nw);
      chk($sformatf("v%0d_wcount", i), word_count, tv[i].nw);
      chk($sformatf("v%0d_a0", i), wa[0], 0);
      chk($sformatf("v%0d_d0", i), wd[0], tv[i].w0);
      if (tv[i].nw > 1) begin
        chk($sformatf("v%0d_a1", i), wa[1], 1);
        chk($sformatf("v%0d_d1", i), wd[1], tv[i].w1);
      end
      chk($sformatf("v%0d_overrun", i), overrun, 0);
    end

    // bad stop bit between good bytes
    do_reset();
    ready = 1'b1;
    send(8'hAA);
    send(8'h55, 1'b0);
    cyc(20);
    chk("ferr_count", ferr_cnt, 1);
    chk("ferr_nowrite", wa.size(), 0);
    send(8'hBB);
    send(8'hCC);
    send(8'hDD);
    cyc(20);
    chk("ferr_nwrites", wa.size(), 1);
    chk("ferr_data", wd[0], 32'hDDCCBBAA);
    chk("ferr_addr", wa[0], 0);

    // memory stalled across two words
    do_reset();
    ready = 1'b0;
    for (int j = 1; j <= 8; j++) send(8'(j));
    cyc(5);
    chk("ovr_flag", overrun, 1);
    chk("ovr_pending", mem_valid, 1);
    chk("ovr_wdata", mem_wdata, 32'h04030201);
    chk("ovr_nowrite", wa.size(), 0);
    ready = 1'b1;
    cyc(5);
    chk("ovr_nwrites", wa.size(), 1);
    chk("ovr_d0", wd[0], 32'h04030201);
    chk("ovr_wcount", word_count, 1);
    wait_done("ovr");
    chk("ovr_final_writes", wa.size(), 1);

    // short glitch, then reset mid-frame
    do_reset();
    ready = 1'b1;
    rx = 1'b0;
    cyc(20);
    rx = 1'b1;
    cyc(2000);
    chk("glitch_done", load_done, 0);
    chk("glitch_nowrite", wa.size(), 0);
    chk("glitch_wcount", word_count, 0);
    send(8'hEF);
    send(8'hBE);
    send(8'hAD);
    send(8'hDE);
    cyc(20);
    chk("pre_rst_data", wd[0], 32'hDEADBEEF);
    rx = 1'b0;
    cyc(CPB);
    rx = 1'b1;
    cyc(CPB);
    rx = 1'b0;
    cyc(100);
    rst = 1'b1;
    rx = 1'b1;
    cyc(2);
    rst = 1'b0;
    wa.delete();
    wd.delete();
    cyc(1);
    chk("midrst_outs", outs(), 64'h0);
    send(8'h78);
    send(8'h56);
    send(8'h34);
    send(8'h12);
    cyc(20);
    chk("midrst_nwrites", wa.size(), 1);
    chk("midrst_addr", wa[0], 0);
    chk("midrst_data", wd[0], 32'h12345678);
    chk("midrst_wcount", word_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
